// File: rtl/csr_timer_bank_pkg.sv
// csr_timer_bank_pkg
//   Shared constants for the CSR timer bank:
//   - CSR number width.
//   - Per-channel CSR offsets: TCFG, TVAL and TICLR.
//   - TCFG/TICLR field positions.
//   - A helper that forms a channel's CSR number.
package csr_timer_bank_pkg;

    localparam int CSR_NUM_WIDTH = 14;

    // Offsets from a channel's TCFG number; each channel occupies a 4-number slot.
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TCFG_OFS  = 14'd0;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TVAL_OFS  = 14'd1;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TICLR_OFS = 14'd3;

    // TCFG = {INITVAL[CNT_WIDTH-1:2], PERIODIC[1], EN[0]}; TICLR.CLR = bit 0.
    localparam int CSR_TCFG_EN          = 0;
    localparam int CSR_TCFG_PERIODIC    = 1;
    localparam int CSR_TCFG_INITVAL_LSB = 2;
    localparam int CSR_TICLR_CLR        = 0;

    function automatic logic [CSR_NUM_WIDTH-1:0] csr_chan_num(
        input logic [CSR_NUM_WIDTH-1:0] base,
        input int                       ch,
        input logic [CSR_NUM_WIDTH-1:0] ofs
    );
        return base + CSR_NUM_WIDTH'(4 * ch) + ofs;
    endfunction

endpackage

// File: rtl/csr_timer_channel.sv
// csr_timer_channel
//   One countdown timer channel. It holds:
//   - TCFG config: {initval, periodic, en}.
//   - The down counter.
//   - A sticky pending bit.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   tick            prescaled decrement strobe
//   cfg_we          masked write to this channel's TCFG
//   clr             TICLR.CLR write-one (already masked)
//   wmask, wvalue   CSR write mask/data, low CNT_WIDTH bits
//   cfg             current TCFG contents
//   cnt             current counter (TVAL)
//   pending         sticky expiry flag
module csr_timer_channel
    import csr_timer_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 cfg_we,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] wmask,
    input  logic [CNT_WIDTH-1:0] wvalue,
    output logic [CNT_WIDTH-1:0] cfg,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 pending
);

    logic [CNT_WIDTH-1:0] cfg_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cfg_new;
    logic [CNT_WIDTH-1:0] reload_cur;
    logic [CNT_WIDTH-1:0] reload_new;
    logic                 en;
    logic                 periodic;
    logic                 idle;
    logic                 fire;

    assign cfg_new    = (wmask & wvalue) | (~wmask & cfg_q);
    assign en         = cfg_q[CSR_TCFG_EN];
    assign periodic   = cfg_q[CSR_TCFG_PERIODIC];
    assign reload_cur = {cfg_q[CNT_WIDTH-1:CSR_TCFG_INITVAL_LSB], 2'b00};
    assign reload_new = {cfg_new[CNT_WIDTH-1:CSR_TCFG_INITVAL_LSB], 2'b00};
    // All-ones is the stopped state a one-shot count lands in after expiring.
    assign idle       = &cnt_q;
    assign fire       = en && tick && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q   <= '0;
            cnt_q   <= '1;
            pending <= 1'b0;
        end else begin
            if (cfg_we)
                cfg_q <= cfg_new;

            // Enabling write reloads immediately, independent of tick.
            // A write that clears EN only stops future decrements.
            if (cfg_we && cfg_new[CSR_TCFG_EN])
                cnt_q <= reload_new;
            else if (en && tick && !idle)
                cnt_q <= (cnt_q == '0 && periodic) ? reload_cur
                                                   : cnt_q - CNT_WIDTH'(1);

            // Expiry beats a simultaneous clear so no interrupt is lost.
            if (fire)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

    assign cfg = cfg_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/csr_timer_bank.sv
// csr_timer_bank
//   Bank of NUM_TIMERS countdown timers behind the shared CSR port.
//   Channel i's registers sit at these CSR numbers:
//     TCFG  = CSR_BASE+4*i
//     TVAL  = CSR_BASE+4*i+1
//     TICLR = CSR_BASE+4*i+3
//   Optional macro CSR_TIMER_STABLE_CNT_EN:
//     defined   -> adds a free-running 64-bit stable counter.
//     undefined -> stable_cnt reads 0.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   csr_re, csr_num, csr_rvalue  combinational read port (0 if unmapped)
//   csr_we, csr_wmask, csr_wvalue masked write port
//   timer_int                    per-channel pending
//   timer_int_any                OR of timer_int
//   stable_cnt                   64-bit stable counter
module csr_timer_bank
    import csr_timer_bank_pkg::*;
#(
    parameter int                       NUM_TIMERS = 1,
    parameter int                       CNT_WIDTH  = 32,
    parameter logic [CSR_NUM_WIDTH-1:0] CSR_BASE   = 14'h41,
    parameter int                       PRESCALE   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_re,
    input  logic [CSR_NUM_WIDTH-1:0] csr_num,
    output logic [31:0]              csr_rvalue,
    input  logic                     csr_we,
    input  logic [31:0]              csr_wmask,
    input  logic [31:0]              csr_wvalue,
    output logic [NUM_TIMERS-1:0]    timer_int,
    output logic                     timer_int_any,
    output logic [63:0]              stable_cnt
);

    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    logic [7:0] presc;
    logic       tick;
    logic       clr_bit;

    logic [NUM_TIMERS-1:0][CNT_WIDTH-1:0] ch_cfg;
    logic [NUM_TIMERS-1:0][CNT_WIDTH-1:0] ch_cnt;

    // Shared prescaler: every channel decrements on the same tick.
    assign tick = (presc == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick)
            presc <= '0;
        else
            presc <= presc + 8'd1;
    end

    assign clr_bit = csr_wmask[CSR_TICLR_CLR] & csr_wvalue[CSR_TICLR_CLR];

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        localparam logic [CSR_NUM_WIDTH-1:0] TCFG_NUM  = csr_chan_num(CSR_BASE, i, CSR_TCFG_OFS);
        localparam logic [CSR_NUM_WIDTH-1:0] TICLR_NUM = csr_chan_num(CSR_BASE, i, CSR_TICLR_OFS);

        logic cfg_we;
        logic clr;

        assign cfg_we = csr_we && (csr_num == TCFG_NUM);
        assign clr    = csr_we && (csr_num == TICLR_NUM) && clr_bit;

        csr_timer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .cfg_we  (cfg_we),
            .clr     (clr),
            .wmask   (csr_wmask[CNT_WIDTH-1:0]),
            .wvalue  (csr_wvalue[CNT_WIDTH-1:0]),
            .cfg     (ch_cfg[i]),
            .cnt     (ch_cnt[i]),
            .pending (timer_int[i])
        );
    end

    // TICLR and unmapped numbers fall through to the zero default.
    always_comb begin
        csr_rvalue = '0;
        if (csr_re) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (csr_num == csr_chan_num(CSR_BASE, i, CSR_TCFG_OFS))
                    csr_rvalue = 32'(ch_cfg[i]);
                if (csr_num == csr_chan_num(CSR_BASE, i, CSR_TVAL_OFS))
                    csr_rvalue = 32'(ch_cnt[i]);
            end
        end
    end

    assign timer_int_any = |timer_int;

`ifdef CSR_TIMER_STABLE_CNT_EN
    logic [63:0] stable_q;

    always_ff @(posedge clk) begin
        if (reset)
            stable_q <= '0;
        else
            stable_q <= stable_q + 64'd1;
    end

    assign stable_cnt = stable_q;
`else
    assign stable_cnt = '0;
`endif

endmodule

// File: tb/tb_csr_timer_bank.sv
// tb_csr_timer_bank
//   Two bank instances share one CSR bus:
//   - u_a: 1 channel,  PRESCALE=1
//   - u_b: 2 channels, PRESCALE=4
//   A cycle-level behavioural model of both instances is checked every cycle.
//   Directed literal expectations pin the model.
module tb_csr_timer_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;

    logic [31:0] rv0, rv1;
    logic [0:0]  ti0;
    logic [1:0]  ti1;
    logic        any0, any1;
    logic [63:0] st0, st1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_timer_bank #(.NUM_TIMERS(1), .CNT_WIDTH(32), .CSR_BASE(14'h41), .PRESCALE(1)) u_a (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(rv0),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .timer_int(ti0), .timer_int_any(any0), .stable_cnt(st0));

    csr_timer_bank #(.NUM_TIMERS(2), .CNT_WIDTH(32), .CSR_BASE(14'h41), .PRESCALE(4)) u_b (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(rv1),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .timer_int(ti1), .timer_int_any(any1), .stable_cnt(st1));

    // ---------------- behavioural model ----------------
    function automatic int nt(input int k); return (k == 0) ? 1 : 2; endfunction
    function automatic int ps(input int k); return (k == 0) ? 1 : 4; endfunction

    bit          model_ok = 1'b0;
    longint      m_cyc;                 // clock edges since reset released
    bit          m_en   [2][2];
    bit          m_per  [2][2];
    bit          m_pend [2][2];
    logic [29:0] m_init [2][2];
    logic [31:0] m_cnt  [2][2];

    always @(posedge clk) begin
        if (reset) begin
            model_ok <= 1'b1;
            m_cyc    <= 0;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 2; c++) begin
                    m_en[k][c]   <= 1'b0;
                    m_per[k][c]  <= 1'b0;
                    m_pend[k][c] <= 1'b0;
                    m_init[k][c] <= '0;
                    m_cnt[k][c]  <= 32'hFFFF_FFFF;
                end
        end else begin
            m_cyc <= m_cyc + 1;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 2; c++) begin
                    automatic int          base = 'h41 + 4 * c;
                    automatic bit          tk   = (m_cyc % ps(k)) == ps(k) - 1;
                    automatic bit          wcfg = csr_we && (int'(csr_num) == base);
                    automatic bit          wclr = csr_we && (int'(csr_num) == base + 3)
                                                  && csr_wmask[0] && csr_wvalue[0];
                    automatic logic [31:0] old  = {m_init[k][c], m_per[k][c], m_en[k][c]};
                    automatic logic [31:0] nv   = (csr_wmask & csr_wvalue) | (~csr_wmask & old);
                    automatic bit          fire = m_en[k][c] && tk && m_cnt[k][c] == 0;
                    if (c < nt(k)) begin
                        if (wcfg) begin
                            m_en[k][c]   <= nv[0];
                            m_per[k][c]  <= nv[1];
                            m_init[k][c] <= nv[31:2];
                        end
                        if (wcfg && nv[0])
                            m_cnt[k][c] <= 32'(nv[31:2]) * 4;
                        else if (m_en[k][c] && tk && m_cnt[k][c] != 32'hFFFF_FFFF) begin
                            if (m_cnt[k][c] == 0)
                                m_cnt[k][c] <= m_per[k][c] ? 32'(m_init[k][c]) * 4 : 32'hFFFF_FFFF;
                            else
                                m_cnt[k][c] <= m_cnt[k][c] - 1;
                        end
                        if (fire)      m_pend[k][c] <= 1'b1;
                        else if (wclr) m_pend[k][c] <= 1'b0;
                    end
                end
        end
    end

    function automatic logic [31:0] exp_rd(input int k);
        if (!csr_re) return 32'h0;
        for (int c = 0; c < nt(k); c++) begin
            if (int'(csr_num) == 'h41 + 4 * c)     return {m_init[k][c], m_per[k][c], m_en[k][c]};
            if (int'(csr_num) == 'h41 + 4 * c + 1) return m_cnt[k][c];
        end
        return 32'h0;
    endfunction

    function automatic logic [63:0] exp_stable();
`ifdef CSR_TIMER_STABLE_CNT_EN
        return 64'(m_cyc);
`else
        return 64'h0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_rd_a",   rv0,  exp_rd(0));
            chk("m_rd_b",   rv1,  exp_rd(1));
            chk("m_int_a",  ti0,  m_pend[0][0]);
            chk("m_int_b",  ti1,  {m_pend[1][1], m_pend[1][0]});
            chk("m_any_a",  any0, m_pend[0][0]);
            chk("m_any_b",  any1, m_pend[1][0] | m_pend[1][1]);
            chk("m_stab_a", st0,  exp_stable());
            chk("m_stab_b", st1,  exp_stable());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(); @(posedge clk); #1; endtask

    task automatic rd(input logic [13:0] n);
        #1; csr_we = 1'b0; csr_re = 1'b1; csr_num = n;
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] v);
        #1; csr_we = 1'b1; csr_re = 1'b1; csr_num = n; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = v;
    endtask

    initial begin
        automatic logic [31:0] per_seq [6] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd4};
        reset = 1'b1; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state.
        rd(14'h42); @(negedge clk);
        chk("rst_tval", rv0, 32'hFFFF_FFFF);
        chk("rst_int", ti0, 1'b0);
        rd(14'h41); #1 chk("rst_tcfg", rv0, 32'h0);

        // One-shot, initval=2: 8 down to 0, then stopped at all-ones with pending.
        wr(14'h41, 32'h9); step(); rd(14'h42); @(negedge clk);
        chk("os_load", rv0, 32'd8);
        for (int v = 7; v >= 0; v--) begin
            step(); @(negedge clk);
            chk("os_count", rv0, 32'(v));
            chk("os_noint", ti0, 1'b0);
        end
        step(); @(negedge clk);
        chk("os_expired", rv0, 32'hFFFF_FFFF);
        chk("os_int", ti0, 1'b1);
        repeat (3) begin step(); @(negedge clk); chk("os_hold", rv0, 32'hFFFF_FFFF); end
        wr(14'h44, 32'h1); step(); rd(14'h41); @(negedge clk);
        chk("os_clr", ti0, 1'b0);

        // Periodic, initval=1: 4,3,2,1,0,4 with pending one cycle after the 0.
        wr(14'h41, 32'h7); step(); rd(14'h42); @(negedge clk);
        chk("per_load", rv0, per_seq[0]);
        for (int i = 1; i < 6; i++) begin
            step(); @(negedge clk);
            chk("per_count", rv0, per_seq[i]);
            chk("per_int", ti0, (i == 5) ? 1'b1 : 1'b0);
        end

        // Clear on a non-firing cycle drops pending; clear during fire loses.
        wr(14'h44, 32'h1); step(); rd(14'h42); @(negedge clk);
        chk("clr_int", ti0, 1'b0);
        chk("clr_tval", rv0, 32'd3);
        repeat (3) begin step(); @(negedge clk); end
        chk("pre_fire", rv0, 32'd0);
        wr(14'h44, 32'h1); step(); rd(14'h42); @(negedge clk);
        chk("set_wins", ti0, 1'b1);
        chk("reload", rv0, 32'd4);
        wr(14'h44, 32'h1); step(); rd(14'h42); @(negedge clk);
        chk("late_clr", ti0, 1'b0);

        // initval=0 one-shot expires on the next tick.
        wr(14'h41, 32'h1); step(); rd(14'h42); @(negedge clk);
        chk("zero_load", rv0, 32'd0);
        step(); @(negedge clk);
        chk("zero_exp", rv0, 32'hFFFF_FFFF);
        chk("zero_int", ti0, 1'b1);
        wr(14'h44, 32'h1); step(); rd(14'h42); @(negedge clk);

        // Channel 1 on the 2-channel, PRESCALE=4 bank.
        wr(14'h45, 32'hD); step(); rd(14'h46); @(negedge clk);
        chk("ch1_load", rv1, 32'd12);
        chk("unmapped", rv0, 32'd0);
        repeat (8) step();
        @(negedge clk);
        chk("ch1_presc", rv1, 32'd10);
        rd(14'h41); #1 chk("ch0_untouched", rv1, 32'h1);
        #1 csr_re = 1'b0; #1 chk("re_low", rv1, 32'h0);

        // Reset mid-count.
        reset = 1'b1; step(); reset = 1'b0; rd(14'h46); @(negedge clk);
        chk("mid_rst_tval", rv1, 32'hFFFF_FFFF);
        rd(14'h45); #1 chk("mid_rst_tcfg", rv1, 32'h0);

        // Stable counter, 100 cycles after reset.
        repeat (100) step();
        @(negedge clk);
`ifdef CSR_TIMER_STABLE_CNT_EN
        chk("stable_100", st0, 64'd100);
`else
        chk("stable_off", st0, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
